// File: rtl/display_scan_ctrl_if.sv
// Bundles the scan enable, digit input and multiplexed-display outputs of display_scan_ctrl.
// master = the side that drives en/digits; slave = the scan controller itself.
interface display_scan_ctrl_if;
    logic        en;
    logic [19:0] digits;
    logic [2:0]  sel;
    logic [3:0]  seg_data;
    logic        blank;
    logic        frame_tick;

    modport master (
        output en, digits,
        input  sel, seg_data, blank, frame_tick
    );

    modport slave (
        input  en, digits,
        output sel, seg_data, blank, frame_tick
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Five-digit multiplexed BCD display scanner: OFF/SHOW/GAP FSM with per-frame digit snapshot.
// Define LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 is always lit).
module display_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int GAP_CYC  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    display_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [19:0] SHOW_LAST = 20'(SCAN_DIV - 1);
    localparam logic [19:0] GAP_LAST  = 20'(GAP_CYC - 1);

    state_t      state_reg, state_next;
    logic [19:0] cnt_reg, cnt_next;
    logic [2:0]  sel_reg, sel_next;
    logic [19:0] snap_reg, snap_next;
    logic [3:0]  seg_reg, seg_next;
    logic        blank_reg, blank_next;
    logic        tick_reg, tick_next;

    // Snapshot split into digit lanes; lanes 5..7 exist only so a 3-bit index stays in range.
    logic [3:0] snap_dig [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dig
            if (gi < 5) begin : g_real
                assign snap_dig[gi] = snap_next[4*gi +: 4];
            end else begin : g_pad
                assign snap_dig[gi] = 4'd0;
            end
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // lz_hi[k]: digit k and every more significant digit of the snapshot are zero.
    logic [7:0] lz_hi;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lz
            if (gi < 5) begin : g_real
                assign lz_hi[gi] = (snap_next[19:4*gi] == '0);
            end else begin : g_pad
                assign lz_hi[gi] = 1'b1;
            end
        end
    endgenerate
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 20'd1;
        sel_next   = sel_reg;
        snap_next  = snap_reg;
        tick_next  = 1'b0;

        if (!bus.en) begin
            state_next = ST_OFF;
        end else begin
            case (state_reg)
                ST_OFF: begin
                    state_next = ST_SHOW;
                end
                ST_SHOW: begin
                    if (cnt_reg == SHOW_LAST) begin
                        state_next = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        state_next = ST_SHOW;
                        if (sel_reg == 3'd4) begin
                            sel_next  = 3'd0;
                            tick_next = 1'b1;
                        end else begin
                            sel_next = sel_reg + 3'd1;
                        end
                    end
                end
                default: begin
                    state_next = ST_OFF;
                end
            endcase
        end

        if (state_next != state_reg) begin
            cnt_next = 20'd0;
        end
        if (state_next == ST_OFF) begin
            sel_next = 3'd0;
            cnt_next = 20'd0;
        end
        // A frame starts whenever SHOW is entered at digit 0, from OFF or after a wrap.
        if (state_next == ST_SHOW && state_reg != ST_SHOW && sel_next == 3'd0) begin
            snap_next = bus.digits;
        end
    end

    always_comb begin
        seg_next   = seg_reg;
        blank_next = 1'b1;
        if (state_next == ST_SHOW) begin
            seg_next = snap_dig[sel_next];
`ifdef LEADING_ZERO_BLANK_EN
            blank_next = (sel_next != 3'd0) && lz_hi[sel_next];
`else
            blank_next = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_OFF;
            cnt_reg   <= 20'd0;
            sel_reg   <= 3'd0;
            snap_reg  <= 20'd0;
            seg_reg   <= 4'd0;
            blank_reg <= 1'b1;
            tick_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
            snap_reg  <= snap_next;
            seg_reg   <= seg_next;
            blank_reg <= blank_next;
            tick_reg  <= tick_next;
        end
    end

    assign bus.sel        = sel_reg;
    assign bus.seg_data   = seg_reg;
    assign bus.blank      = blank_reg;
    assign bus.frame_tick = tick_reg;
endmodule
